// File: rtl/mcu_spi_if.sv
// Signal bundle between the IO MCU SPI pins, the mcu_spi deframer and its clients.
// The slave modport is the deframer's view; the master modport is the MCU/client side.
interface mcu_spi_if;
  logic       spi_csn;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] data_out;
  logic       hid_strobe;
  logic       osd_strobe;
  logic       sdc_strobe;
  logic       hid_start;
  logic       osd_start;
  logic       sdc_start;
  logic [7:0] hid_din;
  logic [7:0] osd_din;
  logic [7:0] sdc_din;
  logic       busy;

  modport slave (
    input  spi_csn, spi_sclk, spi_mosi, hid_din, osd_din, sdc_din,
    output spi_miso, data_out, hid_strobe, osd_strobe, sdc_strobe,
           hid_start, osd_start, sdc_start, busy
  );

  modport master (
    output spi_csn, spi_sclk, spi_mosi, hid_din, osd_din, sdc_din,
    input  spi_miso, data_out, hid_strobe, osd_strobe, sdc_strobe,
           hid_start, osd_start, sdc_start, busy
  );
endinterface

// File: rtl/mcu_spi.sv
// Oversampled mode-0 SPI slave: byte 0 of a frame selects a target, later bytes are strobed to it.
// Define MCU_SPI_SYS_EN to answer target 0 internally with SYS_ID / SYS_VER.
//
// state       | meaning
// ST_DISARMED | after reset; waiting to see CS high before accepting a frame
// ST_ARMED    | CS high, next CS falling edge starts a frame
// ST_ACTIVE   | frame in progress, SCLK edges are decoded
module mcu_spi (
  input  logic clk,
  input  logic reset,
  mcu_spi_if.slave bus
);

`ifdef MCU_SPI_SYS_EN
  localparam logic [7:0] SYS_ID  = 8'h5c;
  localparam logic [7:0] SYS_VER = 8'h01;
`endif

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_csn_s, r_sclk_s, r_mosi_s;
  logic       r_csn_d, r_sclk_d;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_byte_idx;
  logic [7:0] r_target;
  logic       r_tgt_vld;
  logic [7:0] r_tx;
  logic [7:0] r_data_out;
  logic       r_load_d1, r_load_d2;
  logic       r_hid_strobe, r_osd_strobe, r_sdc_strobe;
  logic       r_hid_start, r_osd_start, r_sdc_start;

  logic       w_csn, w_sclk, w_mosi;
  logic       w_csn_rise, w_csn_fall, w_sclk_rise, w_sclk_fall;
  logic       w_frame_start, w_frame_end;
  logic       w_rx_en, w_byte_done, w_first_payload;
  logic [7:0] w_byte;
  logic       w_sel_hid, w_sel_osd, w_sel_sdc;
  logic [7:0] w_tx_load;

  assign w_csn       = r_csn_s[1];
  assign w_sclk      = r_sclk_s[1];
  assign w_mosi      = r_mosi_s[1];
  assign w_csn_rise  = w_csn & ~r_csn_d;
  assign w_csn_fall  = ~w_csn & r_csn_d;
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;

  // CS sync resets low so a frame already running at reset release cannot arm the block
  always_ff @(posedge clk) begin
    if (reset) begin
      r_csn_s  <= 2'b00;
      r_sclk_s <= 2'b00;
      r_mosi_s <= 2'b00;
      r_csn_d  <= 1'b0;
      r_sclk_d <= 1'b0;
    end else begin
      r_csn_s  <= {r_csn_s[0], bus.spi_csn};
      r_sclk_s <= {r_sclk_s[0], bus.spi_sclk};
      r_mosi_s <= {r_mosi_s[0], bus.spi_mosi};
      r_csn_d  <= w_csn;
      r_sclk_d <= w_sclk;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_DISARMED;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      ST_DISARMED: if (w_csn) w_state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (w_csn_fall) begin
          w_state_nxt   = ST_ACTIVE;
          w_frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_csn_rise) begin
          w_state_nxt = ST_ARMED;
          w_frame_end = 1'b1;
        end
      end
      default: w_state_nxt = ST_DISARMED;
    endcase
  end

  assign w_rx_en         = (r_state == ST_ACTIVE) && !w_csn_rise;
  assign w_byte          = {r_shift[6:0], w_mosi};
  assign w_byte_done     = w_rx_en && w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_first_payload = (r_byte_idx == 8'd1);
  assign w_sel_hid       = r_tgt_vld && (r_target == 8'd1);
  assign w_sel_osd       = r_tgt_vld && (r_target == 8'd2);
  assign w_sel_sdc       = r_tgt_vld && (r_target == 8'd3);

  always_comb begin
    w_tx_load = 8'h00;
    if (w_sel_hid)      w_tx_load = bus.hid_din;
    else if (w_sel_osd) w_tx_load = bus.osd_din;
    else if (w_sel_sdc) w_tx_load = bus.sdc_din;
`ifdef MCU_SPI_SYS_EN
    else if (r_tgt_vld && (r_target == 8'd0)) begin
      // byte index has already advanced past the byte that just completed
      if (r_byte_idx == 8'd2)      w_tx_load = SYS_ID;
      else if (r_byte_idx == 8'd3) w_tx_load = SYS_VER;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_byte_idx   <= 8'd0;
      r_target     <= 8'h00;
      r_tgt_vld    <= 1'b0;
      r_tx         <= 8'h00;
      r_data_out   <= 8'h00;
      r_load_d1    <= 1'b0;
      r_load_d2    <= 1'b0;
      r_hid_strobe <= 1'b0;
      r_osd_strobe <= 1'b0;
      r_sdc_strobe <= 1'b0;
      r_hid_start  <= 1'b0;
      r_osd_start  <= 1'b0;
      r_sdc_start  <= 1'b0;
    end else begin
      r_hid_strobe <= 1'b0;
      r_osd_strobe <= 1'b0;
      r_sdc_strobe <= 1'b0;
      r_hid_start  <= 1'b0;
      r_osd_start  <= 1'b0;
      r_sdc_start  <= 1'b0;
      r_load_d1    <= w_byte_done;
      r_load_d2    <= r_load_d1;
      if (r_load_d2) r_tx <= w_tx_load;

      if (w_frame_start) begin
        r_bit_cnt  <= 3'd0;
        r_byte_idx <= 8'd0;
        r_tgt_vld  <= 1'b0;
        r_tx       <= 8'h00;
        r_load_d1  <= 1'b0;
        r_load_d2  <= 1'b0;
      end else if (w_frame_end) begin
        r_tgt_vld  <= 1'b0;
        r_tx       <= 8'h00;
        r_load_d1  <= 1'b0;
        r_load_d2  <= 1'b0;
      end else if (w_rx_en) begin
        if (w_sclk_rise) begin
          r_shift   <= w_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_byte_idx == 8'd0) begin
              r_target  <= w_byte;
              r_tgt_vld <= 1'b1;
            end else if (w_sel_hid || w_sel_osd || w_sel_sdc) begin
              r_data_out   <= w_byte;
              r_hid_strobe <= w_sel_hid;
              r_osd_strobe <= w_sel_osd;
              r_sdc_strobe <= w_sel_sdc;
              r_hid_start  <= w_sel_hid && w_first_payload;
              r_osd_start  <= w_sel_osd && w_first_payload;
              r_sdc_start  <= w_sel_sdc && w_first_payload;
            end
            if (r_byte_idx != 8'hff) r_byte_idx <= r_byte_idx + 8'd1;
          end
        end else if (w_sclk_fall && (r_bit_cnt != 3'd0)) begin
          r_tx <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

  assign bus.spi_miso   = r_tx[7];
  assign bus.data_out   = r_data_out;
  assign bus.hid_strobe = r_hid_strobe;
  assign bus.osd_strobe = r_osd_strobe;
  assign bus.sdc_strobe = r_sdc_strobe;
  assign bus.hid_start  = r_hid_start;
  assign bus.osd_start  = r_osd_start;
  assign bus.sdc_start  = r_sdc_start;
  assign bus.busy       = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_mcu_spi.sv
// Scoreboard bench for mcu_spi: expected strobes and MISO bytes are queued by the
// stimulus and popped by independent monitors.
module tb_mcu_spi;
  localparam int HALF = 8;

  typedef struct {
    logic [2:0] tgt;   // {hid, osd, sdc}
    logic       start;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] val;
    logic       care;
  } miso_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t  q_strobe[$];
  miso_t q_miso[$];
  logic [7:0] tx_bytes[$];
  logic [7:0] got_byte;
  event ev_miso;
  bit   reply_mode = 0;
  int   reply_cnt = 0;

  mcu_spi_if bus ();
  mcu_spi dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor
  always @(negedge clk) begin
    if (!reset && (bus.hid_strobe || bus.osd_strobe || bus.sdc_strobe)) begin
      checks++;
      if (q_strobe.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got tgt=%b data=%0h expected none",
                 {bus.hid_strobe, bus.osd_strobe, bus.sdc_strobe}, bus.data_out);
      end else begin
        exp_t e;
        e = q_strobe.pop_front();
        if ({bus.hid_strobe, bus.osd_strobe, bus.sdc_strobe} !== e.tgt ||
            {bus.hid_start, bus.osd_start, bus.sdc_start} !== (e.start ? e.tgt : 3'b000) ||
            bus.data_out !== e.data) begin
          errors++;
          $display("FAIL strobe: got tgt=%b start=%b data=%0h expected tgt=%b start=%b data=%0h",
                   {bus.hid_strobe, bus.osd_strobe, bus.sdc_strobe},
                   {bus.hid_start, bus.osd_start, bus.sdc_start}, bus.data_out,
                   e.tgt, e.start ? e.tgt : 3'b000, e.data);
        end
      end
    end
  end

  // MISO monitor
  always @(ev_miso) begin
    if (q_miso.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_miso: got %0h expected none", got_byte);
    end else begin
      miso_t m;
      m = q_miso.pop_front();
      if (m.care) chk("miso_byte", {24'd0, got_byte}, {24'd0, m.val});
    end
  end

  // Reply-path driver: change hid_din right after each HID strobe
  always @(negedge clk) begin
    if (reply_mode && bus.hid_strobe) begin
      reply_cnt++;
      if (reply_cnt == 1) bus.hid_din = 8'h5c;
      else if (reply_cnt == 2) bus.hid_din = 8'h42;
    end
  end

  task automatic exp_strobe(input logic [2:0] tgt, input logic start, input logic [7:0] data);
    exp_t e;
    e.tgt = tgt; e.start = start; e.data = data;
    q_strobe.push_back(e);
  endtask

  task automatic exp_miso(input logic [7:0] val, input logic care);
    miso_t m;
    m.val = val; m.care = care;
    q_miso.push_back(m);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      got[7-i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [7:0] g;
    spi_bits(b, 8, g);
    got_byte = g;
    ->ev_miso;
  endtask

  task automatic cs_low();
    bus.spi_csn = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    bus.spi_csn = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic run_frame();
    cs_low();
    chk("busy_in_frame", {31'd0, bus.busy}, 32'd1);
    while (tx_bytes.size() > 0) spi_byte(tx_bytes.pop_front());
    cs_high();
    chk("busy_after_frame", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] dummy;
    reset = 1'b1;
    bus.spi_csn = 1'b1; bus.spi_sclk = 1'b0; bus.spi_mosi = 1'b0;
    bus.hid_din = 8'h99; bus.osd_din = 8'h3c; bus.sdc_din = 8'ha5;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_miso", {31'd0, bus.spi_miso}, 32'd0);
    chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    chk("rst_strobes", {29'd0, bus.hid_strobe, bus.osd_strobe, bus.sdc_strobe}, 32'd0);
    chk("rst_starts", {29'd0, bus.hid_start, bus.osd_start, bus.sdc_start}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2*HALF) @(negedge clk);

    // HID frame with reply path
    reply_mode = 1;
    tx_bytes = '{8'h01, 8'h02, 8'h05, 8'hfb};
    exp_strobe(3'b100, 1'b1, 8'h02);
    exp_strobe(3'b100, 1'b0, 8'h05);
    exp_strobe(3'b100, 1'b0, 8'hfb);
    exp_miso(8'h00, 1); exp_miso(8'h99, 1); exp_miso(8'h5c, 1); exp_miso(8'h42, 1);
    run_frame();
    reply_mode = 0;
    bus.hid_din = 8'h99;
    chk("data_out_hold", {24'd0, bus.data_out}, 32'h000000fb);

    // Invalid target
    tx_bytes = '{8'h07, 8'haa, 8'hbb};
    exp_miso(8'h00, 1); exp_miso(8'h00, 1); exp_miso(8'h00, 1);
    run_frame();

    // SDC frame
    tx_bytes = '{8'h03, 8'h33, 8'h44};
    exp_strobe(3'b001, 1'b1, 8'h33);
    exp_strobe(3'b001, 1'b0, 8'h44);
    exp_miso(8'h00, 1); exp_miso(8'ha5, 1); exp_miso(8'ha5, 1);
    run_frame();

    // Abort after 5 bits of byte 2
    cs_low();
    exp_strobe(3'b010, 1'b1, 8'h10);
    exp_miso(8'h00, 1); exp_miso(8'h3c, 1);
    spi_byte(8'h02);
    spi_byte(8'h10);
    spi_bits(8'h77, 5, dummy);
    cs_high();
    tx_bytes = '{8'h02, 8'h11};
    exp_strobe(3'b010, 1'b1, 8'h11);
    exp_miso(8'h00, 1); exp_miso(8'h3c, 1);
    run_frame();

    // Reset mid-frame with CS held low
    cs_low();
    exp_miso(8'h00, 1);
    spi_byte(8'h01);
    spi_bits(8'h80, 4, dummy);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_after_midreset", {31'd0, bus.busy}, 32'd0);
    chk("miso_after_midreset", {31'd0, bus.spi_miso}, 32'd0);
    exp_miso(8'h00, 1); exp_miso(8'h00, 1);
    spi_byte(8'h66);
    spi_byte(8'h66);
    cs_high();
    tx_bytes = '{8'h01, 8'h21};
    exp_strobe(3'b100, 1'b1, 8'h21);
    exp_miso(8'h00, 1); exp_miso(8'h99, 1);
    run_frame();

    // System target
    tx_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef MCU_SPI_SYS_EN
    exp_miso(8'h00, 1); exp_miso(8'h00, 1); exp_miso(8'h5c, 1); exp_miso(8'h01, 1);
`else
    exp_miso(8'h00, 1); exp_miso(8'h00, 1); exp_miso(8'h00, 1); exp_miso(8'h00, 1);
`endif
    run_frame();

    repeat (10) @(negedge clk);
    chk("strobe_queue_empty", q_strobe.size(), 32'd0);
    chk("miso_queue_empty", q_miso.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
